// File: rtl/elevator_pkg.sv
// elevator_pkg: shared floor count default, call direction and lamp encodings for the hall panel and main controller
package elevator_pkg;
  localparam int FLOORS_DEF = 4;
  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_e;
  localparam logic LAMP_OFF = 1'b0;
  localparam logic LAMP_ON  = 1'b1;
endpackage

// File: rtl/hall_button_debounce.sv
// hall_button_debounce: one hall button; clk/rst_n, raw level in -> 2-flop sync, saturating high counter, one press_event per press, stuck flag
module hall_button_debounce #(
  parameter int DEBOUNCE = 3,
  parameter int STUCK    = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press_event,
  output logic stuck
);
  localparam int CW = $clog2(STUCK + 1);
  logic r_s1, r_s2, r_armed;
  logic [CW-1:0] r_cnt;
  assign press_event = r_s2 && r_armed && r_cnt == CW'(DEBOUNCE - 1);
  assign stuck = r_cnt == CW'(STUCK);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_cnt   <= '0;
      r_armed <= 1'b1;
    end else begin
      r_s1    <= raw;
      r_s2    <= r_s1;
      r_cnt   <= !r_s2 ? '0 : stuck ? r_cnt : r_cnt + 1'b1;
      r_armed <= !r_s2 || (r_armed && !press_event);
    end
endmodule

// File: rtl/hall_call_panel.sv
// hall_call_panel: hall-call front end; raw up/down buttons in -> push pulses, lamps, stuck flags, pending_cnt out; clr_valid/clr_floor/clr_dir/clr_ready clear handshake
module hall_call_panel
  import elevator_pkg::*;
#(
  parameter int FLOORS   = FLOORS_DEF,
  parameter int DEBOUNCE = 3,
  parameter int STUCK    = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [FLOORS-1:0]                btn_up_raw,
  input  logic [FLOORS-1:0]                btn_down_raw,
  output logic [FLOORS-1:0]                push_up,
  output logic [FLOORS-1:0]                push_down,
  output logic [FLOORS-1:0]                lamp_up,
  output logic [FLOORS-1:0]                lamp_down,
  input  logic                             clr_valid,
  input  logic [$clog2(FLOORS)-1:0]        clr_floor,
  input  logic                             clr_dir,
  output logic                             clr_ready,
  output logic [$clog2(2*FLOORS+1)-1:0]    pending_cnt,
  output logic [FLOORS-1:0]                stuck_up,
  output logic [FLOORS-1:0]                stuck_down
);
  localparam int PW = $clog2(2 * FLOORS + 1);
  logic [FLOORS-1:0] w_ev_up, w_ev_dn, w_clr, w_clr_up, w_clr_dn, w_lu_n, w_ld_n;
  logic [PW-1:0] w_cnt_n;
  logic w_unused;
  assign w_unused = btn_up_raw[FLOORS-1] ^ btn_down_raw[0];
  for (genvar f = 0; f < FLOORS; f++) begin : g_fl
    if (f < FLOORS - 1) begin : g_up
      hall_button_debounce #(.DEBOUNCE(DEBOUNCE), .STUCK(STUCK)) u_up (
        .clk(clk), .rst_n(rst_n), .raw(btn_up_raw[f]), .press_event(w_ev_up[f]), .stuck(stuck_up[f])
      );
    end else begin : g_up_tie
      assign w_ev_up[f]  = 1'b0;
      assign stuck_up[f] = 1'b0;
    end
    if (f > 0) begin : g_dn
      hall_button_debounce #(.DEBOUNCE(DEBOUNCE), .STUCK(STUCK)) u_dn (
        .clk(clk), .rst_n(rst_n), .raw(btn_down_raw[f]), .press_event(w_ev_dn[f]), .stuck(stuck_down[f])
      );
    end else begin : g_dn_tie
      assign w_ev_dn[f]    = 1'b0;
      assign stuck_down[f] = 1'b0;
    end
  end
  always_comb begin
    w_clr    = clr_valid ? FLOORS'(1) << clr_floor : '0;
    w_clr_up = dir_e'(clr_dir) == DOWN ? '0 : w_clr;
    w_clr_dn = dir_e'(clr_dir) == DOWN ? w_clr : '0;
    w_lu_n   = (lamp_up | w_ev_up) & ~w_clr_up;
    w_ld_n   = (lamp_down | w_ev_dn) & ~w_clr_dn;
    w_cnt_n  = '0;
    for (int i = 0; i < FLOORS; i++) w_cnt_n = w_cnt_n + PW'(w_lu_n[i]) + PW'(w_ld_n[i]);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      push_up     <= '0;
      push_down   <= '0;
      lamp_up     <= {FLOORS{LAMP_OFF}};
      lamp_down   <= {FLOORS{LAMP_OFF}};
      pending_cnt <= '0;
      clr_ready   <= 1'b0;
    end else begin
      push_up     <= w_ev_up & ~lamp_up & ~w_clr_up;
      push_down   <= w_ev_dn & ~lamp_down & ~w_clr_dn;
      lamp_up     <= w_lu_n;
      lamp_down   <= w_ld_n;
      pending_cnt <= w_cnt_n;
      clr_ready   <= 1'b1;
    end
endmodule

// File: tb/tb_hall_call_panel.sv
// tb_hall_call_panel: directed bench with push-pulse scoreboard for hall_call_panel
module tb_hall_call_panel;
  localparam int F = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [F-1:0] btn_up_raw = '0, btn_down_raw = '0;
  logic clr_valid = 1'b0;
  logic [1:0] clr_floor = '0;
  logic clr_dir = 1'b0;
  logic [F-1:0] push_up, push_down, lamp_up, lamp_down, stuck_up, stuck_down;
  logic clr_ready;
  logic [3:0] pending_cnt;
  int total = 0, bad = 0, cyc = 0;
  typedef struct {int dn; int fl; int at;} exp_t;
  exp_t q[$];
  exp_t e_m;
  hall_call_panel #(.FLOORS(F), .DEBOUNCE(3), .STUCK(64)) dut (
    .clk(clk), .rst_n(rst_n), .btn_up_raw(btn_up_raw), .btn_down_raw(btn_down_raw),
    .push_up(push_up), .push_down(push_down), .lamp_up(lamp_up), .lamp_down(lamp_down),
    .clr_valid(clr_valid), .clr_floor(clr_floor), .clr_dir(clr_dir), .clr_ready(clr_ready),
    .pending_cnt(pending_cnt), .stuck_up(stuck_up), .stuck_down(stuck_down)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask
  task automatic expect_push(input int dn, input int fl, input int at);
    q.push_back('{dn, fl, at});
  endtask
  function automatic logic [31:0] all_out();
    return 32'({push_up, push_down, lamp_up, lamp_down, stuck_up, stuck_down, pending_cnt, clr_ready});
  endfunction
  always @(negedge clk)
    if (rst_n)
      for (int d = 0; d < 2; d++)
        for (int f = 0; f < F; f++)
          if ((d == 1 ? push_down[f] : push_up[f]) === 1'b1) begin
            if (q.size() > 0) e_m = q.pop_front();
            else e_m = '{-1, -1, -1};
            total++;
            assert (d * 100000 + f * 10000 + cyc === e_m.dn * 100000 + e_m.fl * 10000 + e_m.at) else begin
              bad++;
              $error("FAIL push observed dir=%0d floor=%0d cyc=%0d expected dir=%0d floor=%0d cyc=%0d",
                     d, f, cyc, e_m.dn, e_m.fl, e_m.at);
            end
          end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    int c0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", all_out(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 32'(clr_ready), 1);
    c0 = cyc;
    btn_up_raw[1] = 1'b1;
    expect_push(0, 1, c0 + 5);
    wait_to(c0 + 4);
    chk("up1_lamp_early", 32'(lamp_up[1]), 0);
    wait_to(c0 + 5);
    chk("up1_lamp", 32'(lamp_up[1]), 1);
    chk("up1_pending", 32'(pending_cnt), 1);
    wait_to(c0 + 10);
    btn_up_raw[1] = 1'b0;
    wait_to(c0 + 14);
    c0 = cyc;
    btn_down_raw[2] = 1'b1;
    repeat (2) @(negedge clk);
    btn_down_raw[2] = 1'b0;
    wait_to(c0 + 10);
    chk("glitch_dn2_lamp", 32'(lamp_down[2]), 0);
    c0 = cyc;
    btn_up_raw[3] = 1'b1;
    btn_down_raw[0] = 1'b1;
    wait_to(c0 + 70);
    chk("tied_bits", 32'({lamp_up[3], lamp_down[0], stuck_up[3], stuck_down[0]}), 0);
    chk("tied_pending", 32'(pending_cnt), 1);
    btn_up_raw[3] = 1'b0;
    btn_down_raw[0] = 1'b0;
    wait_to(c0 + 75);
    clr_valid = 1'b1;
    clr_floor = 2'd1;
    clr_dir = 1'b0;
    chk("clr_ready", 32'(clr_ready), 1);
    @(negedge clk);
    chk("clr_up1_lamp", 32'(lamp_up[1]), 0);
    chk("clr_up1_pending", 32'(pending_cnt), 0);
    clr_floor = 2'd3;
    @(negedge clk);
    clr_valid = 1'b0;
    chk("clr_nonexist_pending", 32'(pending_cnt), 0);
    c0 = cyc;
    btn_up_raw[1] = 1'b1;
    expect_push(0, 1, c0 + 5);
    wait_to(c0 + 5);
    chk("repress_up1_lamp", 32'(lamp_up[1]), 1);
    chk("repress_up1_pending", 32'(pending_cnt), 1);
    wait_to(c0 + 8);
    btn_up_raw[1] = 1'b0;
    wait_to(c0 + 12);
    c0 = cyc;
    btn_down_raw[2] = 1'b1;
    wait_to(c0 + 4);
    clr_valid = 1'b1;
    clr_floor = 2'd2;
    clr_dir = 1'b1;
    @(negedge clk);
    clr_valid = 1'b0;
    chk("clr_wins_dn2_lamp", 32'(lamp_down[2]), 0);
    chk("clr_wins_pending", 32'(pending_cnt), 1);
    wait_to(c0 + 12);
    chk("armed_consumed_dn2", 32'(lamp_down[2]), 0);
    btn_down_raw[2] = 1'b0;
    wait_to(c0 + 16);
    c0 = cyc;
    btn_up_raw[1] = 1'b1;
    wait_to(c0 + 8);
    chk("lit_press_up1_lamp", 32'(lamp_up[1]), 1);
    chk("lit_press_pending", 32'(pending_cnt), 1);
    btn_up_raw[1] = 1'b0;
    wait_to(c0 + 12);
    c0 = cyc;
    btn_up_raw[0] = 1'b1;
    expect_push(0, 0, c0 + 5);
    wait_to(c0 + 65);
    chk("stuck_up0_early", 32'(stuck_up[0]), 0);
    wait_to(c0 + 66);
    chk("stuck_up0_set", 32'(stuck_up[0]), 1);
    chk("stuck_pending", 32'(pending_cnt), 2);
    wait_to(c0 + 70);
    btn_up_raw[0] = 1'b0;
    wait_to(c0 + 72);
    chk("stuck_up0_hold", 32'(stuck_up[0]), 1);
    wait_to(c0 + 73);
    chk("stuck_up0_clear", 32'(stuck_up[0]), 0);
    chk("stuck_lamp_kept", 32'(lamp_up[0]), 1);
    c0 = cyc;
    btn_up_raw[2] = 1'b1;
    wait_to(c0 + 2);
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", all_out(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    c0 = cyc;
    expect_push(0, 2, c0 + 5);
    wait_to(c0 + 5);
    chk("post_reset_up2_lamp", 32'(lamp_up[2]), 1);
    chk("post_reset_up0_lamp", 32'(lamp_up[0]), 0);
    chk("post_reset_pending", 32'(pending_cnt), 1);
    btn_up_raw[2] = 1'b0;
    wait_to(c0 + 10);
    chk("scoreboard_empty", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hall_call_panel.md
# hall_call_panel

Front-end for the floor hall-call buttons, directly upstream of the elevator main controller. Each hall button is synchronized, debounced and edge-detected, then latched as a pending call and announced to the controller as a one-cycle push pulse on the vectors the controller samples as its up/down request inputs. The controller returns clear commands through a valid/ready handshake when a car serves a floor. The block also drives the hall lamps and a pending-call count.

## Interface
- FLOORS, 4: number of floors, numbered 0..FLOORS-1
- DEBOUNCE, 3: consecutive synchronized-high cycles required to accept a press (≥1)
- STUCK, 64: consecutive synchronized-high cycles after which a button is flagged stuck (>DEBOUNCE)
- clk  in  1  single clock, all state on posedge
- rst_n  in  1  asynchronous, active-low reset
- btn_up_raw  in  FLOORS  raw up-button levels, active-high; bit FLOORS-1 ignored
- btn_down_raw  in  FLOORS  raw down-button levels, active-high; bit 0 ignored
- push_up  out  FLOORS  one-cycle pulse per newly latched up call, feeds controller up requests
- push_down  out  FLOORS  one-cycle pulse per newly latched down call, feeds controller down requests
- lamp_up  out  FLOORS  pending up call per floor
- lamp_down  out  FLOORS  pending down call per floor
- clr_valid  in  1  controller requests a clear
- clr_floor  in  $clog2(FLOORS)  floor to clear
- clr_dir  in  1  0 = UP, 1 = DOWN
- clr_ready  out  1  clear accepted this cycle
- pending_cnt  out  $clog2(2*FLOORS+1)  number of set lamp bits
- stuck_up / stuck_down  out  FLOORS  button held ≥ STUCK cycles

## Operation
- Per button: 2-flop synchronizer → saturating high-counter → armed flag.
- Counter resets to 0 on any synchronized-low cycle; increments while high and saturates at STUCK.
- Press event: counter reaches DEBOUNCE while armed. The event clears armed. Armed is set again only after a synchronized-low cycle, so one press yields one event.
- Press event on a button whose lamp is clear: set lamp, pulse push for one cycle.
- Press event on a button whose lamp is already set: no pulse, lamp unchanged.
- Stuck: stuck bit sets when counter == STUCK and clears on the next synchronized-low cycle. While stuck, no press events are possible; the lamp keeps its value.
- Nonexistent buttons (up at top floor, down at floor 0): tied off. Lamp, push and stuck are constant 0 regardless of raw input.
- Clear handshake:
  - clr_ready = 1 whenever out of reset; a clear is accepted in any cycle with clr_valid.
  - Accepted clear resets lamp[clr_dir][clr_floor] on that edge.
  - Clear of an already-clear or nonexistent button is accepted and has no effect.
  - clr_floor ≥ FLOORS is accepted and has no effect.
- Simultaneous clear and press event on the same button: clear wins. The lamp stays/goes 0, no push pulse, and armed is still consumed.
- pending_cnt equals the popcount of {lamp_up, lamp_down}, registered with the lamps (same cycle as lamp change).

## Timing
- Reset (asynchronous assert, synchronous release): synchronizers, counters, lamps, stuck = 0; armed = 1. All outputs 0, except clr_ready = 0 during reset and 1 from the first edge after release.
- Press latency: raw rising at edge k, held stable → push pulse and lamp set visible after edge k+1+DEBOUNCE, i.e. DEBOUNCE+2 cycles from first sample.
- Glitch shorter than DEBOUNCE synchronized cycles: no event.
- Clear latency: lamp falls after the accepting edge (1 cycle).
- Push pulses are exactly one cycle wide. Multiple floors may pulse in the same cycle.
- Reset asserted mid-debounce discards partial counts. A button still held at release must go low before it can fire again? No: armed = 1 after reset, so a held button fires DEBOUNCE+2 cycles after release.

## Structure
- Shared package elevator_pkg:
  - FLOORS default
  - UP/DOWN direction constants
  - ON/OFF lamp encoding constants, used by the controller
- Sub-module hall_button_debounce: synchronizer, counter, armed flag and stuck flag for one button. It outputs press_event and stuck.
  - Instantiated 2*FLOORS-2 times via generate.
- Top level holds lamps, clear decode, push pulses and popcount.

## Test plan
- DEBOUNCE=3: hold btn_up_raw[1] high for 10 cycles → push_up[1] pulses once, 5 cycles after the first sample; lamp_up[1]=1; pending_cnt=1.
- 2-cycle high glitch on btn_down_raw[2] → no pulse, lamp_down[2]=0.
- btn_up_raw[3] and btn_down_raw[0] held high → push, lamp and stuck stay 0 for those bits.
- Latch lamp_up[1], then clr_valid with floor=1, dir=UP → clr_ready=1; lamp_up[1]=0 next cycle; pending_cnt back to 0. Press again → new pulse.
- Clear of floor 2 down coinciding with its press event → no push pulse, lamp_down[2]=0.
- STUCK=64: hold btn_up_raw[0] for 70 cycles → exactly one pulse; stuck_up[0] rises at counter 64. Release → stuck_up[0] clears. Assert rst_n low mid-debounce on another button → all outputs 0 immediately.
